top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameter div, default 50000, clock cycles per 1 ms timebase tick (div=1: tick every clock).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 a, b  input  1 each  rotary-encoder quadrature channels.
REQ-005 lock  input  1  lock push-button, active-high.
REQ-006 open  input  1  open/enter push-button, active-high.
REQ-007 doorCls  input  1  door-closed sensor, 1 = closed.
REQ-008 actuateLock  output  1  bolt actuator, 1 = bolt engaged.
REQ-009 openCls  output  1  door-may-open indicator, 1 = safe unlocked.
REQ-010 E, RW, RS  output  1 each  HD44780 LCD enable, read/write, register select.
REQ-011 DB  output  8  LCD data bus, 8-bit mode.

Function
REQ-012 Counter 0..div-1 shall produce a one-clock tick enable on wrap; all subsequent timing is in ticks.
REQ-013 a, b, lock, open, doorCls shall be double-flop synchronised to clk, then sampled on each tick.
REQ-014 Button press = sampled 0->1 transition between consecutive ticks; holding gives one press.
REQ-015 Encoder: a sampled 0->1 with b=0 increments entry, with b=1 decrements; entry is 0..99, wraps 99->0 and 0->99.
REQ-016 States: UNLOCKED, LOCKED, ERROR; code register 0..99.
REQ-017 UNLOCKED: actuateLock=0, openCls=1; lock press with doorCls=1 stores entry into code, clears entry to 0, goes LOCKED; lock press with doorCls=0 ignored; open press ignored.
REQ-018 LOCKED: actuateLock=1, openCls=0; open press with entry==code goes UNLOCKED and clears entry; open press with entry!=code goes ERROR and clears entry; lock press ignored.
REQ-019 ERROR: actuateLock=1, openCls=0, encoder and buttons ignored; after 1000 ticks returns to LOCKED.
REQ-020 Same-tick lock and open presses: the press valid in the current state wins (at most one is valid).
REQ-021 RW shall be constantly 0.
REQ-022 LCD init: wait 20 ticks, then write commands 0x38, 0x0C, 0x06, 0x01 (RS=0).
REQ-023 Each byte write: RS/DB set with E=0 for 1 tick, E=1 for 1 tick, E=0 for 1 tick (3 ticks per byte); 2 extra idle ticks after 0x01.
REQ-024 Refresh loop after init, forever: command 0x80, then 11 data bytes (RS=1): 8-char state text, space, entry tens digit, entry units digit (ASCII '0'+n).
REQ-025 State texts: "UNLOCKED", "LOCKED  ", "ERROR   ".
REQ-026 DB and RS shall stay stable while E=1; display reflects state/entry captured at start of each data byte.

Reset
REQ-027 reset=0 shall immediately force: state UNLOCKED, code=0, entry=0, actuateLock=0, openCls=1, E=0, RW=0, RS=0, DB=0x00, tick counter and LCD sequencer to start of init.
REQ-028 Button presses occurring while reset=0 shall be discarded; edge detectors start from current sampled level after release.
REQ-029 Reset asserted mid-operation (any state, mid LCD write) shall abort immediately and restart init after release.

Verification (div=1)
REQ-030 Reset pulse, open pulsed during reset -> after release actuateLock=0, openCls=1, first E pulse with DB=0x38, RS=0 after 20 ticks.
REQ-031 Three encoder steps a 0->1 with b=0, doorCls=1, lock press -> actuateLock=1, openCls=0, code=3, LCD shows "LOCKED   00".
REQ-032 LOCKED code 3, two increments, open -> ERROR, LCD "ERROR    00"; after 1000 ticks back to LOCKED; three increments, open -> UNLOCKED, actuateLock=0.
REQ-033 UNLOCKED, doorCls=0, lock press -> remains UNLOCKED, actuateLock=0.
REQ-034 Entry 0, one step a 0->1 with b=1 -> entry 99, LCD digits "99"; one increment -> "00".
REQ-035 Reset asserted while LOCKED mid LCD byte -> outputs at reset values immediately, init restarts, code cleared.

Source files
------------

// File: rtl/top.sv
// Rotary-encoder combination safe controller with HD44780 status display.
// A divided timebase tick paces everything: button/encoder sampling, the
// UNLOCKED/LOCKED/ERROR lock FSM, and an 8-bit LCD init + refresh sequencer.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   a, b         quadrature encoder channels
//   lock, open   push-buttons, active-high
//   doorCls      door-closed sensor (1 = closed)
//   actuateLock  bolt engaged
//   openCls      door may open (safe unlocked)
//   E, RW, RS    LCD enable, read/write (tied 0), register select
//   DB           LCD data bus (8-bit mode)
module top #(
  parameter int unsigned div = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       lock,
  input  logic       open,
  input  logic       doorCls,
  output logic       actuateLock,
  output logic       openCls,
  output logic       E,
  output logic       RW,
  output logic       RS,
  output logic [7:0] DB
);

  localparam int unsigned CW     = (div > 1) ? $clog2(div) : 1;
  localparam int unsigned EW     = 7;
  localparam int unsigned ERRW   = 10;
  localparam int unsigned ERR_TK = 1000;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKED   = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [1:0] L_WAIT = 2'd0;
  localparam logic [1:0] L_INIT = 2'd1;
  localparam logic [1:0] L_IDLE = 2'd2;
  localparam logic [1:0] L_REFR = 2'd3;

  // Timebase: one-clock tick on counter wrap.
  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = (cnt == CW'(div - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  // Synchroniser kept out of reset so edge detectors can prime from the
  // true input level the moment reset is released.
  logic [4:0] s1, s2;

  always_ff @(posedge clk) begin
    s1 <= {doorCls, open, lock, b, a};
    s2 <= s1;
  end

  // Per-tick samples of a, lock, open; primed suppresses the first tick's edges.
  logic [2:0] samp;
  logic       primed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp   <= '0;
      primed <= 1'b0;
    end else if (tick) begin
      samp   <= {s2[3], s2[2], s2[0]};
      primed <= 1'b1;
    end
  end

  logic enc_p, lock_p, open_p, dir_dn, door_c;

  assign enc_p  = tick && primed && s2[0] && !samp[0];
  assign lock_p = tick && primed && s2[2] && !samp[1];
  assign open_p = tick && primed && s2[3] && !samp[2];
  assign dir_dn = s2[1];
  assign door_c = s2[4];

  // Lock FSM
  logic [1:0]      state, state_n;
  logic [EW-1:0]   entry, entry_n, code, code_n, entry_step;
  logic [ERRW-1:0] err_cnt, err_cnt_n;
  logic            act_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_UNLOCKED;
      entry       <= '0;
      code        <= '0;
      err_cnt     <= '0;
      actuateLock <= 1'b0;
      openCls     <= 1'b1;
    end else begin
      state       <= state_n;
      entry       <= entry_n;
      code        <= code_n;
      err_cnt     <= err_cnt_n;
      actuateLock <= act_n;
      openCls     <= !act_n;
    end
  end

  // Encoder step with 0..99 wraparound.
  always_comb begin
    entry_step = entry;
    if (dir_dn) entry_step = (entry == EW'(0))  ? EW'(99) : entry - EW'(1);
    else        entry_step = (entry == EW'(99)) ? EW'(0)  : entry + EW'(1);
  end

  always_comb begin
    state_n   = state;
    entry_n   = entry;
    code_n    = code;
    err_cnt_n = err_cnt;
    case (state)
      ST_UNLOCKED: begin
        if (lock_p && door_c) begin
          code_n  = entry;
          entry_n = '0;
          state_n = ST_LOCKED;
        end else if (enc_p) begin
          entry_n = entry_step;
        end
      end
      ST_LOCKED: begin
        if (open_p) begin
          entry_n   = '0;
          err_cnt_n = '0;
          state_n   = (entry == code) ? ST_UNLOCKED : ST_ERROR;
        end else if (enc_p) begin
          entry_n = entry_step;
        end
      end
      ST_ERROR: begin
        if (tick) begin
          if (err_cnt == ERRW'(ERR_TK - 1)) state_n = ST_LOCKED;
          else err_cnt_n = err_cnt + ERRW'(1);
        end
      end
      default: state_n = ST_UNLOCKED;
    endcase
    act_n = (state_n != ST_UNLOCKED);
  end

  // Byte table: {RS, DB} for init command idx or refresh slot idx.
  function automatic logic [8:0] lcd_byte(input logic refresh, input logic [3:0] idx,
                                          input logic [1:0] st, input logic [EW-1:0] ent);
    logic [63:0]   txt;
    logic [63:0]   sh;
    logic [EW-1:0] tens, units;
    logic [8:0]    r;
    case (st)
      ST_UNLOCKED: txt = "UNLOCKED";
      ST_LOCKED:   txt = "LOCKED  ";
      default:     txt = "ERROR   ";
    endcase
    tens  = ent / EW'(10);
    units = ent % EW'(10);
    sh    = txt << {idx - 4'd1, 3'b000};
    r     = 9'h000;
    if (!refresh) begin
      case (idx)
        4'd0:    r = {1'b0, 8'h38};
        4'd1:    r = {1'b0, 8'h0C};
        4'd2:    r = {1'b0, 8'h06};
        default: r = {1'b0, 8'h01};
      endcase
    end else begin
      case (idx)
        4'd0:    r = {1'b0, 8'h80};
        4'd9:    r = {1'b1, 8'h20};
        4'd10:   r = {1'b1, 8'h30 + {1'b0, tens}};
        4'd11:   r = {1'b1, 8'h30 + {1'b0, units}};
        default: r = {1'b1, sh[63:56]};
      endcase
    end
    return r;
  endfunction

  // LCD sequencer: each byte is setup (E=0), strobe (E=1), hold (E=0).
  logic [1:0] lst, lst_n, lph, lph_n;
  logic [4:0] lcnt, lcnt_n;
  logic [3:0] lidx, lidx_n;
  logic       e_n, rs_n, load;
  logic [7:0] db_n;
  logic [8:0] byte_c;

  assign RW = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lst  <= L_WAIT;
      lph  <= '0;
      lcnt <= '0;
      lidx <= '0;
      E    <= 1'b0;
      RS   <= 1'b0;
      DB   <= 8'h00;
    end else begin
      lst  <= lst_n;
      lph  <= lph_n;
      lcnt <= lcnt_n;
      lidx <= lidx_n;
      E    <= e_n;
      RS   <= rs_n;
      DB   <= db_n;
    end
  end

  always_comb begin
    lst_n  = lst;
    lph_n  = lph;
    lcnt_n = lcnt;
    lidx_n = lidx;
    e_n    = E;
    rs_n   = RS;
    db_n   = DB;
    load   = 1'b0;
    byte_c = 9'h000;
    if (tick) begin
      case (lst)
        L_WAIT: begin
          if (lcnt == 5'd19) begin
            lst_n  = L_INIT;
            lidx_n = '0;
            lph_n  = '0;
            load   = 1'b1;
          end else begin
            lcnt_n = lcnt + 5'd1;
          end
        end
        L_IDLE: begin
          if (lcnt == 5'd1) begin
            lst_n  = L_REFR;
            lidx_n = '0;
            lph_n  = '0;
            load   = 1'b1;
          end else begin
            lcnt_n = lcnt + 5'd1;
          end
        end
        default: begin
          case (lph)
            2'd0: begin
              lph_n = 2'd1;
              e_n   = 1'b1;
            end
            2'd1: begin
              lph_n = 2'd2;
              e_n   = 1'b0;
            end
            default: begin
              e_n = 1'b0;
              if (lst == L_INIT && lidx == 4'd3) begin
                lst_n  = L_IDLE;
                lcnt_n = '0;
                lph_n  = '0;
              end else begin
                lph_n  = '0;
                load   = 1'b1;
                lidx_n = (lst == L_REFR && lidx == 4'd11) ? 4'd0 : lidx + 4'd1;
              end
            end
          endcase
        end
      endcase
    end
    // State/entry are captured here, at the start of each byte.
    if (load) begin
      byte_c = lcd_byte(lst_n == L_REFR, lidx_n, state, entry);
      rs_n   = byte_c[8];
      db_n   = byte_c[7:0];
      e_n    = 1'b0;
    end
  end

endmodule

// File: tb/tb_top.sv
// Directed bench for top (div=1): lock/unlock/error flow, encoder wrap,
// LCD init timing and refresh text, asynchronous reset behaviour.
module tb_top;

  logic       clk, reset, a, b, lock, open, doorCls;
  logic       actuateLock, openCls, E, RW, RS;
  logic [7:0] DB;

  top #(.div(1)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .lock(lock), .open(open),
    .doorCls(doorCls), .actuateLock(actuateLock), .openCls(openCls),
    .E(E), .RW(RW), .RS(RS), .DB(DB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int frames   = 0;
  int cur      = 11;
  logic       prev_e = 1'b0;
  logic [7:0] line [0:10];

  always @(posedge clk) cyc <= cyc + 1;

  // LCD shadow: 0x80 homes the cursor, then 11 data bytes complete a frame.
  always @(negedge clk) begin
    if (!reset) begin
      cur    = 11;
      prev_e = 1'b0;
    end else begin
      if (E && !prev_e) begin
        if (!RS && DB == 8'h80) cur = 0;
        else if (RS && cur < 11) begin
          line[cur] = DB;
          cur = cur + 1;
          if (cur == 11) frames = frames + 1;
        end
      end
      prev_e = E;
    end
  end

  task automatic check(input string tag, input logic [87:0] got, input logic [87:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic is_lock);
    if (is_lock) lock = 1'b1; else open = 1'b1;
    cycles(4);
    lock = 1'b0;
    open = 1'b0;
    cycles(4);
  endtask

  task automatic enc(input logic down);
    b = down;
    cycles(4);
    a = 1'b1;
    cycles(4);
    a = 1'b0;
    cycles(4);
  endtask

  // Wait for two completed frames so the last one was written entirely afterwards.
  task automatic check_line(input string tag, input logic [87:0] exp);
    int f0;
    int n;
    logic [87:0] v;
    f0 = frames;
    n  = 0;
    while (frames < f0 + 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (frames < f0 + 2) check({tag, "_timeout"}, 88'(frames - f0), 88'(2));
    v = '0;
    for (int i = 0; i < 11; i++) v = {v[79:0], line[i]};
    check(tag, v, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_act"},  88'(actuateLock), 88'(1'b0));
    check({tag, "_open"}, 88'(openCls),     88'(1'b1));
    check({tag, "_e"},    88'(E),           88'(1'b0));
    check({tag, "_rs"},   88'(RS),          88'(1'b0));
    check({tag, "_db"},   88'(DB),          88'(8'h00));
    check({tag, "_rw"},   88'(RW),          88'(1'b0));
  endtask

  // After release: E quiet for 20 ticks, then first strobe carries 0x38 command.
  task automatic check_init(input string tag);
    int hi;
    int n;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (E) hi++;
    end
    check({tag, "_quiet"}, 88'(hi), 88'(0));
    n = 0;
    while (!E && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_e"},  88'(E),  88'(1'b1));
    check({tag, "_db"}, 88'(DB), 88'(8'h38));
    check({tag, "_rs"}, 88'(RS), 88'(1'b0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    reset = 1'b0; a = 1'b0; b = 1'b0; lock = 1'b0; open = 1'b0; doorCls = 1'b1;
    cycles(2);
    open = 1'b1;
    cycles(2);
    open = 1'b0;
    check_reset_vals("rst");
    reset = 1'b1;
    check_init("init");

    // Enter 3, lock with door closed.
    repeat (3) enc(1'b0);
    check_line("unl_03", "UNLOCKED 03");
    press(1'b1);
    check(".lock_act",  88'(actuateLock), 88'(1'b1));
    check(".lock_open", 88'(openCls),     88'(1'b0));
    check_line("locked_00", "LOCKED   00");

    // Wrong code (2) -> ERROR; encoder ignored; back to LOCKED after 1000 ticks.
    repeat (2) enc(1'b0);
    c0 = cyc;
    press(1'b0);
    check("err_act", 88'(actuateLock), 88'(1'b1));
    enc(1'b0);
    check_line("err_00", "ERROR    00");
    while (cyc < c0 + 900) @(posedge clk);
    check_line("err_late", "ERROR    00");
    while (cyc < c0 + 1010) @(posedge clk);
    check_line("relock_00", "LOCKED   00");

    // Correct code -> UNLOCKED.
    repeat (3) enc(1'b0);
    check_line("locked_03", "LOCKED   03");
    press(1'b0);
    check("unl_act",  88'(actuateLock), 88'(1'b0));
    check("unl_open", 88'(openCls),     88'(1'b1));
    check_line("unl_00", "UNLOCKED 00");

    // Door open: lock ignored.
    doorCls = 1'b0;
    cycles(4);
    press(1'b1);
    check("door_act",  88'(actuateLock), 88'(1'b0));
    check("door_open", 88'(openCls),     88'(1'b1));
    doorCls = 1'b1;
    cycles(4);

    // Encoder wrap both ways.
    enc(1'b1);
    check_line("wrap_99", "UNLOCKED 99");
    enc(1'b0);
    check_line("wrap_00", "UNLOCKED 00");

    // Lock with code 5, then reset mid LCD strobe.
    repeat (5) enc(1'b0);
    press(1'b1);
    check("l5_act", 88'(actuateLock), 88'(1'b1));
    repeat (2) enc(1'b0);
    n = 0;
    @(negedge clk);
    while (!E && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2 reset = 1'b0;
    #1 check_reset_vals("midrst");
    cycles(3);
    reset = 1'b1;
    check_init("reinit");
    check_line("post_rst", "UNLOCKED 00");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
